// File: rtl/ws2812b_pkg.sv
// Shared constants for the WS2812B receiver: line timing at 12 MHz, default
// decode thresholds, receiver state encodings and GRB field positions.
package ws2812b_pkg;

    // Nominal line timing in 12 MHz clock cycles (83.3 ns each).
    localparam int T0H  = 5;     // high time of a 0 bit
    localparam int T1H  = 10;    // high time of a 1 bit
    localparam int TBIT = 15;    // full bit period

    // Default decode thresholds in clock cycles.
    localparam int DFLT_MIN_HIGH     = 2;
    localparam int DFLT_BIT_THRESH   = 7;
    localparam int DFLT_MAX_HIGH     = 20;
    localparam int DFLT_RESET_CYCLES = 600;   // 50 us latch gap
    localparam int DFLT_LED_COUNT    = 24;

    localparam int PIX_BITS = 24;

    // Receiver states.
    localparam logic [1:0] HUNT  = 2'd0;   // waiting for a latch gap before decoding
    localparam logic [1:0] ARMED = 2'd1;   // gap seen, waiting for the first rising edge
    localparam logic [1:0] RECV  = 2'd2;   // decoding bits of a frame

    // Field positions inside a received GRB word (first received bit = bit 23).
    localparam int G_MSB = 23;
    localparam int G_LSB = 16;
    localparam int R_MSB = 15;
    localparam int R_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

endpackage

// File: rtl/ws2812b_pulse_meter.sv
// Synchronizes the raw data line, measures high and low run lengths and turns
// them into per-bit, too-long, rising-edge and latch-gap events.
module ws2812b_pulse_meter
    import ws2812b_pkg::*;
#(
    parameter int MIN_HIGH     = DFLT_MIN_HIGH,
    parameter int BIT_THRESH   = DFLT_BIT_THRESH,
    parameter int MAX_HIGH     = DFLT_MAX_HIGH,
    parameter int RESET_CYCLES = DFLT_RESET_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic bit_stb,    // valid-width high pulse just ended
    output logic bit_val,    // decoded value, qualified by bit_stb
    output logic too_long,   // high pulse longer than MAX_HIGH just ended
    output logic gap,        // low run is about to reach RESET_CYCLES
    output logic rise        // synchronized line just went high
);

    // hi_cnt must be able to hold MAX_HIGH+1 so that too-long pulses stay distinguishable.
    localparam int HI_W = $clog2(MAX_HIGH + 2);
    localparam int LO_W = $clog2(RESET_CYCLES + 1);

    localparam logic [HI_W-1:0] HI_SAT = HI_W'(MAX_HIGH + 1);
    localparam logic [HI_W-1:0] HI_MIN = HI_W'(MIN_HIGH);
    localparam logic [HI_W-1:0] HI_MAX = HI_W'(MAX_HIGH);
    localparam logic [HI_W-1:0] HI_THR = HI_W'(BIT_THRESH);
    localparam logic [LO_W-1:0] LO_SAT = LO_W'(RESET_CYCLES);
    localparam logic [LO_W-1:0] LO_ARM = LO_W'(RESET_CYCLES - 1);

    logic            s1_q, s1_d;
    logic            s2_q, s2_d;
    logic            s2_dly_q, s2_dly_d;
    logic [HI_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [LO_W-1:0] lo_cnt_q, lo_cnt_d;
    logic            fall;

    // Next-state for the synchronizer chain and the saturating run-length counters.
    always_comb begin
        s1_d     = din;
        s2_d     = s1_q;
        s2_dly_d = s2_q;
        if (s2_q) begin
            hi_cnt_d = (hi_cnt_q == HI_SAT) ? hi_cnt_q : hi_cnt_q + HI_W'(1);
            lo_cnt_d = '0;
        end else begin
            hi_cnt_d = '0;
            lo_cnt_d = (lo_cnt_q == LO_SAT) ? lo_cnt_q : lo_cnt_q + LO_W'(1);
        end
    end

    // Register synchronizer and counters; reset clears everything.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s2_dly_q <= 1'b0;
            hi_cnt_q <= '0;
            lo_cnt_q <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s2_dly_q <= s2_dly_d;
            hi_cnt_q <= hi_cnt_d;
            lo_cnt_q <= lo_cnt_d;
        end
    end

    // Edge events; on a fall hi_cnt still holds the width of the pulse that just ended.
    always_comb begin
        fall     = !s2_q && s2_dly_q;
        rise     = s2_q && !s2_dly_q;
        bit_stb  = fall && (hi_cnt_q >= HI_MIN) && (hi_cnt_q <= HI_MAX);
        too_long = fall && (hi_cnt_q > HI_MAX);
        bit_val  = (hi_cnt_q >= HI_THR);
        // Fires once, in the cycle whose edge brings lo_cnt to RESET_CYCLES.
        gap      = !s2_q && (lo_cnt_q == LO_ARM);
    end

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B stream receiver: decodes GRB pixels from the single-wire line,
// numbers them within a frame and reports frame end, errors and overflow.
module ws2812b_rx
    import ws2812b_pkg::*;
#(
    parameter int   LED_COUNT    = DFLT_LED_COUNT,
    parameter int   MIN_HIGH     = DFLT_MIN_HIGH,
    parameter int   BIT_THRESH   = DFLT_BIT_THRESH,
    parameter int   MAX_HIGH     = DFLT_MAX_HIGH,
    parameter int   RESET_CYCLES = DFLT_RESET_CYCLES,
    localparam int  IDX_W        = $clog2(LED_COUNT)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             din,
    output logic             pix_valid,
    output logic [23:0]      pix_grb,
    output logic [IDX_W-1:0] pix_index,
    output logic             frame_done,
    output logic [IDX_W:0]   frame_len,
    output logic             err,
    output logic             ovf,
    output logic             busy
);

    localparam logic [IDX_W:0] IDX_LIMIT = (IDX_W + 1)'(LED_COUNT);
    localparam logic [4:0]     LAST_BIT  = 5'(PIX_BITS - 1);

    logic bit_stb, bit_val, too_long, gap, rise;

    ws2812b_pulse_meter #(
        .MIN_HIGH     (MIN_HIGH),
        .BIT_THRESH   (BIT_THRESH),
        .MAX_HIGH     (MAX_HIGH),
        .RESET_CYCLES (RESET_CYCLES)
    ) u_meter (
        .clk      (clk),
        .resetn   (resetn),
        .din      (din),
        .bit_stb  (bit_stb),
        .bit_val  (bit_val),
        .too_long (too_long),
        .gap      (gap),
        .rise     (rise)
    );

    logic [1:0]       state_q, state_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [23:0]      sr_q, sr_d;
    logic [IDX_W:0]   idx_q, idx_d;
    logic             seen_q, seen_d;       // at least one valid bit in this RECV
    logic             pix_valid_q, pix_valid_d;
    logic [23:0]      pix_grb_q, pix_grb_d;
    logic [IDX_W-1:0] pix_index_q, pix_index_d;
    logic             frame_done_q, frame_done_d;
    logic [IDX_W:0]   frame_len_q, frame_len_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;

    // Frame state machine, bit assembly and output strobe generation.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        sr_d         = sr_q;
        idx_d        = idx_q;
        seen_d       = seen_q;
        pix_valid_d  = 1'b0;
        pix_grb_d    = pix_grb_q;
        pix_index_d  = pix_index_q;
        frame_done_d = 1'b0;
        frame_len_d  = frame_len_q;
        err_d        = 1'b0;
        ovf_d        = 1'b0;

        case (state_q)
            HUNT: begin
                bit_cnt_d = '0;
                idx_d     = '0;
                seen_d    = 1'b0;
                if (gap) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                bit_cnt_d = '0;
                idx_d     = '0;
                seen_d    = 1'b0;
                if (rise) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (too_long) begin
                    // Framing is lost; only a fresh latch gap can resynchronize.
                    err_d     = 1'b1;
                    state_d   = HUNT;
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    seen_d    = 1'b0;
                end else if (bit_stb) begin
                    seen_d = 1'b1;
                    sr_d   = {sr_q[22:0], bit_val};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (idx_q < IDX_LIMIT) begin
                            pix_valid_d = 1'b1;
                            pix_grb_d   = {sr_q[22:0], bit_val};
                            pix_index_d = idx_q[IDX_W-1:0];
                            idx_d       = idx_q + (IDX_W + 1)'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else if (gap) begin
                    state_d = ARMED;
                    // A RECV that only ever saw glitches is not reported as a frame.
                    if (seen_q) begin
                        frame_done_d = 1'b1;
                        frame_len_d  = idx_q;
                        err_d        = (bit_cnt_q != 5'd0);
                    end
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    seen_d    = 1'b0;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State and output registers; reset drops any frame in progress.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            sr_q         <= '0;
            idx_q        <= '0;
            seen_q       <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_grb_q    <= '0;
            pix_index_q  <= '0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            sr_q         <= sr_d;
            idx_q        <= idx_d;
            seen_q       <= seen_d;
            pix_valid_q  <= pix_valid_d;
            pix_grb_q    <= pix_grb_d;
            pix_index_q  <= pix_index_d;
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
            err_q        <= err_d;
            ovf_q        <= ovf_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_grb    = pix_grb_q;
    assign pix_index  = pix_index_q;
    assign frame_done = frame_done_q;
    assign frame_len  = frame_len_q;
    assign err        = err_q;
    assign ovf        = ovf_q;
    assign busy       = (state_q == RECV);

endmodule
